// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if -- control/status bundle for pc_sequencer.
//   master: drives stall, branch, rel, target, call, ret; observes pc and RAS status.
//   slave : the sequencer itself (consumes controls, produces pc/ras_cnt/ras_ovf/ras_unf).
// Parameters: PC_W (pc/target width), RAS_DEPTH (sets ras_cnt width = clog2(RAS_DEPTH)+1).
interface pc_sequencer_if #(
  parameter int PC_W      = 12,
  parameter int RAS_DEPTH = 4
);
  logic                           stall;
  logic                           branch;
  logic                           rel;
  logic [PC_W-1:0]                target;
  logic                           call;
  logic                           ret;
  logic [PC_W-1:0]                pc;
  logic [$clog2(RAS_DEPTH):0]     ras_cnt;
  logic                           ras_ovf;
  logic                           ras_unf;

  modport master (
    output stall, branch, rel, target, call, ret,
    input  pc, ras_cnt, ras_ovf, ras_unf
  );

  modport slave (
    input  stall, branch, rel, target, call, ret,
    output pc, ras_cnt, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter sequencer with optional return-address stack.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : pc_sequencer_if.slave
//          in : stall (hold all state), branch, rel (target is signed offset),
//               target, call (jump + push pc+STEP), ret (pop into pc)
//          out: pc (registered), ras_cnt (valid entries), ras_ovf / ras_unf
//               (one-cycle pulses on push overwrite / ret with empty stack)
// Next-pc priority: ret > call|branch > increment. Jump targets are aligned by
// clearing the low ALIGN_BITS bits.
// Build option: define PC_SEQ_RAS_EN to include the return-address stack.
// Without it, call acts as branch, ret acts as increment, ras_* outputs are 0.
module pc_sequencer #(
  parameter int PC_W       = 12,
  parameter int STEP       = 4,
  parameter int ALIGN_BITS = 2,
  parameter int RESET_PC   = 0,
  parameter int RAS_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PC_W-1:0] MASK   = {PC_W{1'b1}} << ALIGN_BITS;
  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC) & MASK;

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] jmp_pc;

  assign seq_pc = pc + PC_W'(STEP);
  assign jmp_pc = (bus.rel ? pc + bus.target : bus.target) & MASK;
  assign bus.pc = pc;

`ifdef PC_SEQ_RAS_EN
  logic [PC_W-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]   sp;     // next write slot; when full it is also the oldest entry
  logic [CW-1:0]   cnt;
  logic            ovf;
  logic            unf;
  logic            full;
  logic            do_push;

  assign full    = (cnt == CW'(RAS_DEPTH));
  assign do_push = !bus.stall && !bus.ret && bus.call;

  assign bus.ras_cnt = cnt;
  assign bus.ras_ovf = ovf;
  assign bus.ras_unf = unf;

  // Storage needs no reset; only pointer and count are cleared.
  always_ff @(posedge clk) begin
    if (do_push) stack[sp] <= seq_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= RST_PC;
      sp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (bus.stall) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= 1'b0;
      unf <= 1'b0;
      if (bus.ret) begin
        if (cnt != '0) begin
          pc  <= stack[sp - 1'b1];
          sp  <= sp - 1'b1;
          cnt <= cnt - 1'b1;
        end else begin
          pc  <= seq_pc;
          unf <= 1'b1;
        end
      end else if (bus.call) begin
        pc <= jmp_pc;
        sp <= sp + 1'b1;
        if (full) ovf <= 1'b1;
        else      cnt <= cnt + 1'b1;
      end else if (bus.branch) begin
        pc <= jmp_pc;
      end else begin
        pc <= seq_pc;
      end
    end
  end
`else
  assign bus.ras_cnt = '0;
  assign bus.ras_ovf = 1'b0;
  assign bus.ras_unf = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RST_PC;
    end else if (!bus.stall) begin
      if (bus.ret)                      pc <= seq_pc;
      else if (bus.call || bus.branch)  pc <= jmp_pc;
      else                              pc <= seq_pc;
    end
  end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer (PC_W=12, STEP=4, ALIGN_BITS=2, RESET_PC=0,
// RAS_DEPTH=4). Expected results follow the stack-enabled build when
// PC_SEQ_RAS_EN is defined, otherwise the plain-sequencer behaviour.
module tb_pc_sequencer;
`ifdef PC_SEQ_RAS_EN
  localparam bit R = 1'b1;
`else
  localparam bit R = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(12), .RAS_DEPTH(4)) bus ();

  pc_sequencer #(
    .PC_W(12), .STEP(4), .ALIGN_BITS(2), .RESET_PC(0), .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       name;
    logic [11:0] pc;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t q[$];
  int   ntests = 0;
  int   nfail  = 0;

  // Monitor: one expectation per rising edge, sampled just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      ntests++;
      if (bus.pc !== e.pc || bus.ras_cnt !== e.cnt ||
          bus.ras_ovf !== e.ovf || bus.ras_unf !== e.unf) begin
        nfail++;
        $display("FAIL %s: got pc=%h cnt=%0d ovf=%b unf=%b, expected pc=%h cnt=%0d ovf=%b unf=%b",
                 e.name, bus.pc, bus.ras_cnt, bus.ras_ovf, bus.ras_unf,
                 e.pc, e.cnt, e.ovf, e.unf);
      end
    end
  end

  // Drive inputs (called at a falling edge), queue the result due at the next rising edge.
  task automatic step(input string nm, input logic st, input logic br, input logic rl,
                      input logic cl, input logic rt, input logic [11:0] tg,
                      input logic [11:0] epc, input int ecnt, input logic eovf,
                      input logic eunf);
    exp_t e;
    bus.stall = st; bus.branch = br; bus.rel = rl;
    bus.call = cl;  bus.ret = rt;    bus.target = tg;
    e.name = nm; e.pc = epc; e.cnt = 3'(ecnt); e.ovf = eovf; e.unf = eunf;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Immediate (asynchronous) check without waiting for a clock.
  task automatic chk_now(input string nm, input logic [11:0] epc, input int ecnt);
    ntests++;
    if (bus.pc !== epc || bus.ras_cnt !== 3'(ecnt) || bus.ras_ovf !== 1'b0 ||
        bus.ras_unf !== 1'b0) begin
      nfail++;
      $display("FAIL %s: got pc=%h cnt=%0d ovf=%b unf=%b, expected pc=%h cnt=%0d ovf=0 unf=0",
               nm, bus.pc, bus.ras_cnt, bus.ras_ovf, bus.ras_unf, epc, ecnt);
    end
  endtask

  initial begin
    bus.stall = 0; bus.branch = 0; bus.rel = 0;
    bus.call = 0;  bus.ret = 0;    bus.target = '0;
    #1;
    chk_now("reset_state", 12'h000, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Free-running increment and wrap
    step("inc1",   0,0,0,0,0, 12'h000, 12'h004, 0, 0, 0);
    step("inc2",   0,0,0,0,0, 12'h000, 12'h008, 0, 0, 0);
    step("inc3",   0,0,0,0,0, 12'h000, 12'h00C, 0, 0, 0);
    step("ld_ffc", 0,1,0,0,0, 12'hFFC, 12'hFFC, 0, 0, 0);
    step("wrap",   0,0,0,0,0, 12'h000, 12'h000, 0, 0, 0);

    // Branch targets
    step("ld_100",    0,1,0,0,0, 12'h100, 12'h100, 0, 0, 0);
    step("rel_neg",   0,1,1,0,0, 12'hFF0, 12'h0F0, 0, 0, 0);
    step("abs_align", 0,1,0,0,0, 12'h2A7, 12'h2A4, 0, 0, 0);

    // Single call/return
    step("ld_010", 0,1,0,0,0, 12'h010, 12'h010, 0, 0, 0);
    step("call1",  0,0,0,1,0, 12'h200, 12'h200, R ? 1 : 0, 0, 0);
    step("ret1",   0,0,0,0,1, 12'h000, R ? 12'h014 : 12'h204, 0, 0, 0);

    // Overflow / underflow
    step("ld_000", 0,1,0,0,0, 12'h000, 12'h000, 0, 0, 0);
    step("c1", 0,0,0,1,0, 12'h100, 12'h100, R ? 1 : 0, 0, 0);
    step("c2", 0,0,0,1,0, 12'h200, 12'h200, R ? 2 : 0, 0, 0);
    step("c3", 0,0,0,1,0, 12'h300, 12'h300, R ? 3 : 0, 0, 0);
    step("c4", 0,0,0,1,0, 12'h400, 12'h400, R ? 4 : 0, 0, 0);
    step("c5_ovf", 0,0,0,1,0, 12'h500, 12'h500, R ? 4 : 0, R, 0);
    step("r1", 0,0,0,0,1, 12'h000, R ? 12'h404 : 12'h504, R ? 3 : 0, 0, 0);
    step("r2", 0,0,0,0,1, 12'h000, R ? 12'h304 : 12'h508, R ? 2 : 0, 0, 0);
    step("r3", 0,0,0,0,1, 12'h000, R ? 12'h204 : 12'h50C, R ? 1 : 0, 0, 0);
    step("r4", 0,0,0,0,1, 12'h000, R ? 12'h104 : 12'h510, 0, 0, 0);
    step("r5_unf",    0,0,0,0,1, 12'h000, R ? 12'h108 : 12'h514, 0, 0, R);
    step("stall_ret", 1,0,0,0,1, 12'h000, R ? 12'h108 : 12'h514, 0, 0, 0);

    // Stall and ret+call priority
    step("ld_600", 0,1,0,0,0, 12'h600, 12'h600, 0, 0, 0);
    step("call7",  0,0,0,1,0, 12'h700, 12'h700, R ? 1 : 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("stall_call", 1,0,0,1,0, 12'h800, 12'h700, R ? 1 : 0, 0, 0);
    step("ret_call", 0,0,0,1,1, 12'h900, R ? 12'h604 : 12'h704, 0, 0, 0);

    // Asynchronous reset mid-sequence
    step("ld_500", 0,1,0,0,0, 12'h500, 12'h500, 0, 0, 0);
    step("pc1",    0,0,0,1,0, 12'h100, 12'h100, R ? 1 : 0, 0, 0);
    step("pc2",    0,0,0,1,0, 12'h200, 12'h200, R ? 2 : 0, 0, 0);
    step("pc3",    0,0,0,1,0, 12'h520, 12'h520, R ? 3 : 0, 0, 0);
    bus.stall = 1; bus.branch = 0; bus.rel = 0; bus.call = 0; bus.ret = 0;
    #2 rst = 1'b1;
    #1 chk_now("async_rst", 12'h000, 0);
    #1 rst = 1'b0;
    step("post_rst_stall", 1,0,0,0,0, 12'h000, 12'h000, 0, 0, 0);
    step("post_rst_ret",   0,0,0,0,1, 12'h000, 12'h004, 0, 0, R);
    step("post_rst_inc",   0,0,0,0,0, 12'h000, 12'h008, 0, 0, 0);

    ntests++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no completion by 50000, expected completion");
    $fatal(1, "timeout");
  end
endmodule
